// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU and result-select encodings,
// immediate formats and the control bundle driven to the execute stage.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  // Legal base-ISA opcodes that need no datapath action in this pipeline.
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    jump:       1'b0,
    alu_src:    1'b0,
    result_src: 2'd0,
    alu_ctrl:   4'd0
  };

  // ALU op from funct3; alt_bit is instr[30], honoured as SUB only when allow_sub.
  function automatic logic [3:0] alu_op_decode(input logic [2:0] f3,
                                               input logic       alt_bit,
                                               input logic       allow_sub);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (allow_sub && alt_bit) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_bit ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Immediate generator: builds the sign-extended RV32I immediate for the
// selected format. IMM_NONE yields zero.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  input  imm_type_e   imm_type_i,
  output logic [31:0] imm_o
);

  // Select and sign-extend the immediate field for the instruction format.
  always_comb begin
    imm_o = 32'd0;
    case (imm_type_i)
      IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm_o = {instr_i[31:12], 12'd0};
      IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// IF/ID pipeline register with RV32I decoder and load-use bubble insertion.
// Optional build macro DECODE_ILLEGAL_TRAP_EN adds the illegal_instr output;
// without it, illegal encodings quietly decode as NOP control.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            ready_in,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [31:0]     imm,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            alu_src,
  output logic [1:0]      result_src,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic            illegal_instr,
`endif
  output logic [3:0]      alu_ctrl
);

  logic            valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic [4:0] rd_s;

  ctrl_t     ctrl_dec_s;
  ctrl_t     ctrl_s;
  imm_type_e imm_type_s;
  logic      legal_s;
  logic      uses_rs1_s;
  logic      uses_rs2_s;
  logic      hazard_s;
  logic      capture_s;

  assign opcode_s = instr_q[6:0];
  assign funct3_s = instr_q[14:12];
  assign funct7_s = instr_q[31:25];
  assign rs1_s    = instr_q[19:15];
  assign rs2_s    = instr_q[24:20];
  assign rd_s     = instr_q[11:7];

  // Decode opcode/funct fields into control, immediate format and legality.
  always_comb begin
    ctrl_dec_s = CTRL_NOP;
    imm_type_s = IMM_NONE;
    legal_s    = 1'b0;
    uses_rs1_s = 1'b0;
    uses_rs2_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
        if (funct7_s == 7'b0000000) begin
          legal_s = 1'b1;
        end else if (funct7_s == 7'b0100000) begin
          legal_s = (funct3_s == 3'b000) || (funct3_s == 3'b101);
        end else begin
          legal_s = 1'b0;
        end
        ctrl_dec_s.reg_write = 1'b1;
        ctrl_dec_s.alu_ctrl  = alu_op_decode(funct3_s, instr_q[30], 1'b1);
      end
      OP_I: begin
        uses_rs1_s = 1'b1;
        imm_type_s = IMM_I;
        if (funct3_s == 3'b001) begin
          legal_s = (funct7_s == 7'b0000000);
        end else if (funct3_s == 3'b101) begin
          legal_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
        end else begin
          legal_s = 1'b1;
        end
        ctrl_dec_s.reg_write = 1'b1;
        ctrl_dec_s.alu_src   = 1'b1;
        ctrl_dec_s.alu_ctrl  = alu_op_decode(funct3_s, instr_q[30], 1'b0);
      end
      OP_LOAD: begin
        uses_rs1_s = 1'b1;
        imm_type_s = IMM_I;
        legal_s    = (funct3_s != 3'b011) && (funct3_s != 3'b110) && (funct3_s != 3'b111);
        ctrl_dec_s.reg_write  = 1'b1;
        ctrl_dec_s.mem_read   = 1'b1;
        ctrl_dec_s.alu_src    = 1'b1;
        ctrl_dec_s.result_src = RES_MEM;
        ctrl_dec_s.alu_ctrl   = ALU_ADD;
      end
      OP_STORE: begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
        imm_type_s = IMM_S;
        legal_s    = (funct3_s == 3'b000) || (funct3_s == 3'b001) || (funct3_s == 3'b010);
        ctrl_dec_s.mem_write = 1'b1;
        ctrl_dec_s.alu_src   = 1'b1;
        ctrl_dec_s.alu_ctrl  = ALU_ADD;
      end
      OP_BRANCH: begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
        imm_type_s = IMM_B;
        legal_s    = (funct3_s != 3'b010) && (funct3_s != 3'b011);
        ctrl_dec_s.branch   = 1'b1;
        ctrl_dec_s.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        imm_type_s = IMM_J;
        legal_s    = 1'b1;
        ctrl_dec_s.reg_write  = 1'b1;
        ctrl_dec_s.jump       = 1'b1;
        ctrl_dec_s.result_src = RES_PC4;
      end
      OP_JALR: begin
        uses_rs1_s = 1'b1;
        imm_type_s = IMM_I;
        legal_s    = (funct3_s == 3'b000);
        ctrl_dec_s.reg_write  = 1'b1;
        ctrl_dec_s.jump       = 1'b1;
        ctrl_dec_s.alu_src    = 1'b1;
        ctrl_dec_s.result_src = RES_PC4;
        ctrl_dec_s.alu_ctrl   = ALU_ADD;
      end
      OP_LUI: begin
        imm_type_s = IMM_U;
        legal_s    = 1'b1;
        ctrl_dec_s.reg_write = 1'b1;
        ctrl_dec_s.alu_src   = 1'b1;
        ctrl_dec_s.alu_ctrl  = ALU_PASSB;
      end
      OP_AUIPC: begin
        imm_type_s = IMM_U;
        legal_s    = 1'b1;
        ctrl_dec_s.reg_write = 1'b1;
        ctrl_dec_s.alu_src   = 1'b1;
        ctrl_dec_s.alu_ctrl  = ALU_ADD;
      end
      OP_FENCE: begin
        legal_s = (funct3_s == 3'b000);
      end
      OP_SYSTEM: begin
        // Only ECALL / EBREAK are base-ISA; both are no-ops to this datapath.
        legal_s = (instr_q[31:21] == 11'd0) && (instr_q[19:7] == 13'd0);
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Illegal encodings fall back to NOP; writes to x0 are suppressed as no-ops.
  always_comb begin
    ctrl_s = CTRL_NOP;
    if (legal_s) begin
      ctrl_s           = ctrl_dec_s;
      ctrl_s.reg_write = ctrl_dec_s.reg_write && (rd_s != 5'd0);
    end else begin
      ctrl_s = CTRL_NOP;
    end
  end

  imm_gen u_imm_gen (
    .instr_i    (instr_q),
    .imm_type_i (legal_s ? imm_type_s : IMM_NONE),
    .imm_o      (imm)
  );

  assign hazard_s = valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                    ((uses_rs1_s && (rs1_s == ex_rd)) || (uses_rs2_s && (rs2_s == ex_rd)));
  assign valid_out = valid_q && !hazard_s;
  assign ready_out = !valid_q || (ready_in && !hazard_s);
  assign capture_s = valid_in && ready_out;

  assign pc_out     = pc_q;
  assign rs1_addr   = rs1_s;
  assign rs2_addr   = rs2_s;
  assign rd_addr    = ctrl_s.reg_write ? rd_s : 5'd0;
  assign reg_write  = ctrl_s.reg_write;
  assign mem_read   = ctrl_s.mem_read;
  assign mem_write  = ctrl_s.mem_write;
  assign branch     = ctrl_s.branch;
  assign jump       = ctrl_s.jump;
  assign alu_src    = ctrl_s.alu_src;
  assign result_src = ctrl_s.result_src;
  assign alu_ctrl   = ctrl_s.alu_ctrl;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal_instr = valid_out && !legal_s;
`endif

  // Pipeline register: flush beats capture, capture beats consume, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (capture_s) begin
      valid_q <= 1'b1;
      instr_q <= instr_in;
      pc_q    <= pc_in;
    end else if (valid_q && ready_in && !hazard_s) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

endmodule
